// File: rtl/mod_counter_cfg.sv
// Programmable modulo up/down enable counter with shadowed modulus and a
// zero-latency terminal-count enable for cascading stages.
module mod_counter_cfg #(
    parameter int WIDTH       = 12,
    parameter int DEFAULT_MOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] mod_q,
    output logic             next_en
);

    localparam logic [WIDTH-1:0] DEF_MOD = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] m_req;
    logic [WIDTH-1:0] mod_m1;
    logic             term;

    // A modulus of 1 would make the counter stick; it is raised to 2.
    always_comb begin
        m_req = mod_val;
        if (mod_val == ZERO) begin
            m_req = DEF_MOD;
        end else if (mod_val == ONE) begin
            m_req = TWO;
        end
    end

    // Counting up, anything at or past the last legal value wraps.
    assign mod_m1 = shadow_q - ONE;
    assign term   = dir ? (cnt_q >= mod_m1) : (cnt_q == ZERO);

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (clr) begin
            cnt_d    = ZERO;
            shadow_d = m_req;
        end else if (load) begin
            cnt_d = (load_val > mod_m1) ? mod_m1 : load_val;
        end else if (en) begin
            if (term) begin
                cnt_d    = dir ? ZERO : (m_req - ONE);
                shadow_d = m_req;
            end else begin
                cnt_d = dir ? (cnt_q + ONE) : (cnt_q - ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= ZERO;
            shadow_q <= DEF_MOD;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign next_en = rst_n & en & ~clr & ~load & term;
    assign cnt     = cnt_q;
    assign mod_q   = shadow_q;

endmodule

// File: tb/tb_mod_counter_cfg.sv
// Randomized and directed checks of mod_counter_cfg against an arithmetic
// model of the counting rules.
module tb_mod_counter_cfg;

    localparam int WIDTH = 12;
    localparam int DEFM  = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en, dir, clr, load;
    logic [WIDTH-1:0] load_val, mod_val;
    logic [WIDTH-1:0] cnt, mod_q;
    logic             next_en;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt, m_mod;
    int pulses;

    mod_counter_cfg #(.WIDTH(WIDTH), .DEFAULT_MOD(DEFM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .mod_val(mod_val),
        .cnt(cnt), .mod_q(mod_q), .next_en(next_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mreq(input int mv);
        if (mv == 0) return DEFM;
        if (mv == 1) return 2;
        return mv;
    endfunction

    // Called right after a falling edge: apply inputs, check the terminal
    // enable, let one rising edge happen, then check the registered state.
    task automatic step(input bit e, input bit d, input bit c, input bit l,
                        input int lv, input int mv);
        bit exp_ne;
        bit at_end;
        en = e; dir = d; clr = c; load = l;
        load_val = lv[WIDTH-1:0]; mod_val = mv[WIDTH-1:0];
        #1;
        at_end = d ? (m_cnt >= m_mod - 1) : (m_cnt == 0);
        exp_ne = e && !c && !l && at_end;
        check("next_en", {31'd0, next_en}, {31'd0, exp_ne});
        if (next_en) pulses++;
        @(posedge clk);
        if (c) begin
            m_cnt = 0;
            m_mod = mreq(mv);
        end else if (l) begin
            m_cnt = (lv < m_mod - 1) ? lv : m_mod - 1;
        end else if (e) begin
            if (at_end) begin
                m_cnt = d ? 0 : mreq(mv) - 1;
                m_mod = mreq(mv);
            end else begin
                m_cnt = d ? m_cnt + 1 : m_cnt - 1;
            end
        end
        @(negedge clk);
        check("cnt", {20'd0, cnt}, m_cnt);
        check("mod_q", {20'd0, mod_q}, m_mod);
        $display("t=%0t en=%0b dir=%0b clr=%0b load=%0b lv=%0d mv=%0d -> cnt=%0d mod_q=%0d",
                 $time, e, d, c, l, lv, mv, cnt, mod_q);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_mod = DEFM;
    endtask

    initial begin
        int mv_cur;
        bit d_cur;
        rst_n = 1'b0; en = 1'b1; dir = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = '0; mod_val = '0;
        @(negedge clk);
        @(negedge clk);
        // Down-counting at zero would be terminal, but reset forces it low.
        check("rst_cnt", {20'd0, cnt}, 0);
        check("rst_mod_q", {20'd0, mod_q}, DEFM);
        check("rst_next_en", {31'd0, next_en}, 0);
        rst_n = 1'b1;
        m_cnt = 0; m_mod = DEFM;

        // Default modulus, full period up.
        pulses = 0;
        for (int i = 0; i < 1000; i++) step(1, 1, 0, 0, 0, 0);
        check("pulses_1000", pulses, 1);
        check("wrap_cnt", {20'd0, cnt}, 0);

        // Down by 60 from reset: immediate borrow into 59.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 120; i++) step(1, 0, 0, 0, 0, 60);
        check("pulses_60", pulses, 2);

        // Modulus change mid-count only lands at the next wrap.
        do_reset();
        for (int i = 0; i < 500; i++) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 520; i++) step(1, 1, 0, 0, 0, 10);
        check("shrunk_mod", {20'd0, mod_q}, 10);

        // Load clamps to current modulus; clr beats load beats en.
        step(1, 1, 1, 0, 0, 60);
        step(1, 1, 0, 1, 75, 60);
        check("load_clamp", {20'd0, cnt}, 59);
        step(1, 1, 0, 1, 75, 60);
        step(1, 1, 1, 1, 7, 1);
        check("clr_mod2", {20'd0, mod_q}, 2);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 1);

        // Randomized mix.
        mv_cur = 0; d_cur = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mv_cur = $urandom_range(0, 40);
            if ($urandom_range(0, 15) == 0) d_cur = ~d_cur;
            step(($urandom_range(0, 7) != 0), d_cur,
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 $urandom_range(0, 63), mv_cur);
        end

        // Asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 0, 0);
        en = 1'b1; dir = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("arst_cnt", {20'd0, cnt}, 0);
        check("arst_mod_q", {20'd0, mod_q}, DEFM);
        check("arst_next_en", {31'd0, next_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0; m_mod = DEFM;
        step(1, 1, 0, 0, 0, 0);
        check("first_after_rst", {20'd0, cnt}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
